// File: rtl/tile_config_decoder.sv
// rtl/tile_config_decoder.sv - tile-side config bus receiver: address match, register write/readback, load tracking
module tile_config_decoder #(
    parameter logic [15:0] TILE_ID    = 16'h0015,
    parameter logic [7:0]  FEATURE    = 8'h00,
    parameter int          NUM_REGS   = 8,
    parameter int          IDLE_LIMIT = 4
) (
    input  logic                     clk_in,
    input  logic                     reset_in,
    input  logic [31:0]              config_addr_in,
    input  logic [31:0]              config_data_in,
    input  logic                     config_read_in,
    output logic [NUM_REGS*32-1:0]   config_regs_out,
    output logic [31:0]              read_data_out,
    output logic                     read_valid_out,
    output logic                     config_done_out,
    output logic [15:0]              write_count_out,
    output logic                     error_out
);

    typedef enum logic [1:0] {
        ST_UNCONF  = 2'd0,
        ST_LOADING = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    // 9-bit so that NUM_REGS = 256 still compares correctly against an 8-bit reg_id
    localparam logic [8:0] NUM_REGS_W   = 9'(NUM_REGS);
    localparam logic [7:0] IDLE_LIMIT_W = 8'(IDLE_LIMIT);

    logic [31:0]            s0_addr_q;
    logic [31:0]            s0_data_q;
    logic                   s0_read_q;

    logic [NUM_REGS*32-1:0] regs_q;
    logic [NUM_REGS*32-1:0] regs_d;
    logic [31:0]            read_data_q;
    logic [31:0]            read_data_d;
    logic                   read_valid_q;
    logic [15:0]            write_count_q;
    logic [15:0]            write_count_d;
    logic                   error_q;
    logic [7:0]             idle_cnt_q;
    logic [7:0]             idle_cnt_d;
    state_t                 state_q;
    state_t                 state_d;
    logic                   done_q;

    logic [7:0]             reg_id;
    logic                   hit;
    logic                   reg_ok;
    logic                   wr_ok;
    logic                   rd_hit;
    logic [31:0]            rd_val;

    // stage 0: capture the bus word exactly as presented
    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            s0_addr_q <= 32'h0;
            s0_data_q <= 32'h0;
            s0_read_q <= 1'b0;
        end else begin
            s0_addr_q <= config_addr_in;
            s0_data_q <= config_data_in;
            s0_read_q <= config_read_in;
        end
    end

    // stage 1 decode; address 0 is the idle word and never matches
    always_comb begin
        reg_id = s0_addr_q[31:24];
        hit    = (s0_addr_q != 32'h0) && (s0_addr_q[15:0] == TILE_ID)
                 && (s0_addr_q[23:16] == FEATURE);
        reg_ok = ({1'b0, reg_id} < NUM_REGS_W);
        wr_ok  = hit && !s0_read_q && reg_ok;
        rd_hit = hit && s0_read_q;
    end

    // register write next-state and readback mux; out-of-range ids read back as 0
    always_comb begin
        regs_d = regs_q;
        rd_val = 32'h0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (wr_ok && (reg_id == 8'(i))) begin
                regs_d[32*i +: 32] = s0_data_q;
            end
            if (reg_id == 8'(i)) begin
                rd_val = regs_q[32*i +: 32];
            end
        end
    end

    // readback data holds its last value between reads; write counter saturates
    always_comb begin
        read_data_d   = rd_hit ? rd_val : read_data_q;
        write_count_d = write_count_q;
        if (wr_ok && (write_count_q != 16'hFFFF)) begin
            write_count_d = write_count_q + 16'd1;
        end
    end

    // config registers, readback, counter and sticky error
    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            regs_q        <= '0;
            read_data_q   <= 32'h0;
            read_valid_q  <= 1'b0;
            write_count_q <= 16'h0;
            error_q       <= 1'b0;
        end else begin
            regs_q        <= regs_d;
            read_data_q   <= read_data_d;
            read_valid_q  <= rd_hit;
            write_count_q <= write_count_d;
            if (hit && !reg_ok) begin
                error_q <= 1'b1;
            end
        end
    end

    // load-progress FSM next state; any hit (read, error or write) restarts the idle count
    always_comb begin
        state_d    = state_q;
        idle_cnt_d = idle_cnt_q;
        case (state_q)
            ST_UNCONF: begin
                if (wr_ok) begin
                    state_d    = ST_LOADING;
                    idle_cnt_d = 8'd0;
                end
            end
            ST_LOADING: begin
                if (hit) begin
                    idle_cnt_d = 8'd0;
                end else if (8'(idle_cnt_q + 8'd1) == IDLE_LIMIT_W) begin
                    state_d    = ST_DONE;
                    idle_cnt_d = 8'd0;
                end else begin
                    idle_cnt_d = idle_cnt_q + 8'd1;
                end
            end
            ST_DONE: begin
                if (wr_ok) begin
                    state_d    = ST_LOADING;
                    idle_cnt_d = 8'd0;
                end
            end
            default: begin
                state_d    = ST_UNCONF;
                idle_cnt_d = 8'd0;
            end
        endcase
    end

    // FSM state register; done flag is registered alongside so it mirrors state == DONE
    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            state_q    <= ST_UNCONF;
            idle_cnt_q <= 8'd0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idle_cnt_q <= idle_cnt_d;
            done_q     <= (state_d == ST_DONE);
        end
    end

    assign config_regs_out = regs_q;
    assign read_data_out   = read_data_q;
    assign read_valid_out  = read_valid_q;
    assign config_done_out = done_q;
    assign write_count_out = write_count_q;
    assign error_out       = error_q;

endmodule

// File: tb/tb_tile_config_decoder.sv
// tb/tb_tile_config_decoder.sv - directed table-driven bench for tile_config_decoder
module tb_tile_config_decoder;
    localparam int NREG = 8;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [31:0]          addr;
    logic [31:0]          data;
    logic                 rd;
    logic [NREG*32-1:0]   regs_out;
    logic [31:0]          rdata;
    logic                 rvalid;
    logic                 done;
    logic [15:0]          wcount;
    logic                 err;

    int total = 0;
    int bad   = 0;

    tile_config_decoder #(
        .TILE_ID    (16'h0015),
        .FEATURE    (8'h00),
        .NUM_REGS   (NREG),
        .IDLE_LIMIT (4)
    ) dut (
        .clk_in          (clk),
        .reset_in        (rst_n),
        .config_addr_in  (addr),
        .config_data_in  (data),
        .config_read_in  (rd),
        .config_regs_out (regs_out),
        .read_data_out   (rdata),
        .read_valid_out  (rvalid),
        .config_done_out (done),
        .write_count_out (wcount),
        .error_out       (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic        rd;
        int          idles;
        logic        rv;
        logic [31:0] rdata;
        logic [15:0] cnt;
        logic        err;
        int          ridx;
        logic [31:0] rval;
        logic        done;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] reg_of(input int i);
        return regs_out[32*i +: 32];
    endfunction

    function automatic vec_t mk(input logic [31:0] a, input logic [31:0] d, input logic r,
                                input int idl, input logic ev, input logic [31:0] ed,
                                input logic [15:0] ec, input logic ee, input int ri,
                                input logic [31:0] rv, input logic edn);
        vec_t v;
        v.addr = a; v.data = d; v.rd = r; v.idles = idl;
        v.rv = ev; v.rdata = ed; v.cnt = ec; v.err = ee;
        v.ridx = ri; v.rval = rv; v.done = edn;
        return v;
    endfunction

    task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic r);
        @(negedge clk);
        addr = a;
        data = d;
        rd   = r;
    endtask

    initial begin
        int pulses;
        logic [31:0] pdata;

        //            addr          data          rd idl rv rdata         cnt    err reg rval          done
        vecs[0]  = mk(32'h04000016, 32'h11111111, 0, 6, 0, 32'h0,        16'd0, 0,  4, 32'h0,        0);
        vecs[1]  = mk(32'h04010015, 32'h22222222, 0, 6, 0, 32'h0,        16'd0, 0,  4, 32'h0,        0);
        vecs[2]  = mk(32'h00000000, 32'h33333333, 0, 6, 0, 32'h0,        16'd0, 0,  0, 32'h0,        0);
        vecs[3]  = mk(32'h08000015, 32'h44444444, 0, 6, 0, 32'h0,        16'd0, 1,  0, 32'h0,        0);
        vecs[4]  = mk(32'h09000015, 32'h00000000, 1, 1, 1, 32'h0,        16'd0, 1,  0, 32'h0,        0);
        vecs[5]  = mk(32'h02000015, 32'hDEADBEEF, 0, 4, 0, 32'h0,        16'd1, 1,  2, 32'hDEADBEEF, 1);
        vecs[6]  = mk(32'h02000015, 32'h00000000, 1, 1, 1, 32'hDEADBEEF, 16'd1, 1,  2, 32'hDEADBEEF, 1);
        vecs[7]  = mk(32'h00000015, 32'hA5A5A5A5, 0, 2, 0, 32'hDEADBEEF, 16'd2, 1,  0, 32'hA5A5A5A5, 0);
        vecs[8]  = mk(32'h07000015, 32'h77777777, 0, 3, 0, 32'hDEADBEEF, 16'd3, 1,  7, 32'h77777777, 0);
        vecs[9]  = mk(32'h07000015, 32'h00000000, 1, 1, 1, 32'h77777777, 16'd3, 1,  7, 32'h77777777, 1);
        vecs[10] = mk(32'h04010015, 32'h55555555, 0, 1, 0, 32'h77777777, 16'd3, 1,  4, 32'h0,        1);

        rst_n = 1'b0;
        addr  = 32'h0;
        data  = 32'h0;
        rd    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_count", 32'(wcount), 32'h0);
        chk("reset_done", 32'(done), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // idle after reset: nothing should move
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (rvalid) pulses++;
        end
        chk("idle_rvalid_pulses", 32'(pulses), 32'h0);
        chk("idle_done", 32'(done), 32'h0);
        chk("idle_count", 32'(wcount), 32'h0);
        chk("idle_err", 32'(err), 32'h0);
        for (int i = 0; i < NREG; i++) begin
            chk($sformatf("idle_reg%0d", i), reg_of(i), 32'h0);
        end

        // table: one operation, then idle cycles before the done check
        for (int v = 0; v < 11; v++) begin
            drive(vecs[v].addr, vecs[v].data, vecs[v].rd);
            drive(32'h0, 32'h0, 1'b0);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_rvalid", v), 32'(rvalid), 32'(vecs[v].rv));
            chk($sformatf("v%0d_rdata", v), rdata, vecs[v].rdata);
            chk($sformatf("v%0d_count", v), 32'(wcount), 32'(vecs[v].cnt));
            chk($sformatf("v%0d_err", v), 32'(err), 32'(vecs[v].err));
            chk($sformatf("v%0d_reg%0d", v, vecs[v].ridx), reg_of(vecs[v].ridx), vecs[v].rval);
            repeat (vecs[v].idles) @(posedge clk);
            #1;
            chk($sformatf("v%0d_done", v), 32'(done), 32'(vecs[v].done));
        end

        // back-to-back write then read of the same register
        drive(32'h01000015, 32'h12345678, 1'b0);
        drive(32'h01000015, 32'h0, 1'b1);
        drive(32'h0, 32'h0, 1'b0);
        pulses = 0;
        pdata  = 32'h0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (rvalid) begin
                pulses++;
                pdata = rdata;
            end
        end
        chk("b2b_pulses", 32'(pulses), 32'h1);
        chk("b2b_rdata", pdata, 32'h12345678);
        chk("b2b_reg1", reg_of(1), 32'h12345678);
        chk("b2b_count", 32'(wcount), 32'h4);

        // reload from DONE
        repeat (6) @(posedge clk);
        #1;
        chk("reload_done_before", 32'(done), 32'h1);
        drive(32'h00000015, 32'hCAFEF00D, 1'b0);
        drive(32'h0, 32'h0, 1'b0);
        @(posedge clk);
        #1;
        chk("reload_done_low", 32'(done), 32'h0);
        chk("reload_reg0", reg_of(0), 32'hCAFEF00D);
        repeat (3) @(posedge clk);
        #1;
        chk("reload_done_3idle", 32'(done), 32'h0);
        @(posedge clk);
        #1;
        chk("reload_done_4idle", 32'(done), 32'h1);
        chk("reload_count", 32'(wcount), 32'h5);

        // asynchronous reset in the middle of a write
        drive(32'h03000015, 32'h01020304, 1'b0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        addr  = 32'h0;
        data  = 32'h0;
        #1;
        chk("arst_count", 32'(wcount), 32'h0);
        chk("arst_err", 32'(err), 32'h0);
        chk("arst_done", 32'(done), 32'h0);
        chk("arst_rvalid", 32'(rvalid), 32'h0);
        chk("arst_rdata", rdata, 32'h0);
        for (int i = 0; i < NREG; i++) begin
            chk($sformatf("arst_reg%0d", i), reg_of(i), 32'h0);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("post_rst_reg3", reg_of(3), 32'h0);
        chk("post_rst_count", 32'(wcount), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
